layers_ctrl: RTL
================

# layers_ctrl

Job sequencer for the `layers` datapath. It snoops the configuration bus for job geometry and is armed by a start command. It then meters a raw image word stream into `layers`, framing each MAC pass with `image_last` and stopping after exactly enough passes for the requested number of pooled outputs. It counts result handshakes and reports completion, sitting between the image fetch stream and `layers`.

## Interface
Parameters:
- CFG_DWIDTH, 32, config data width
- CFG_AWIDTH, 5, config address width
- GROUP_NB, 4, image words per bus beat
- IMG_WIDTH, 16, image word width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- cfg_data  in  CFG_DWIDTH  config data (snooped)
- cfg_addr  in  CFG_AWIDTH  config address
- cfg_valid  in  1  config write strobe
- src_bus  in  GROUP_NB*IMG_WIDTH  upstream image beat
- src_val  in  1  upstream valid
- src_rdy  out  1  upstream ready
- image_bus  out  GROUP_NB*IMG_WIDTH  to `layers`; equals src_bus
- image_last  out  1  last beat of current MAC pass
- image_val  out  1  beat valid to `layers`
- image_rdy  in  1  `layers` ready
- result_val  in  1  `layers` result valid (snooped)
- result_rdy  in  1  sink ready (snooped)
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky: start rejected; cleared by next accepted start

## Operation
- Config snoop, all on cfg_valid:
  - CFG_LAYERS: pool_nb <= cfg_data[15:8].
  - CFG_CTRL_LEN: pass_len <= cfg_data[15:0].
  - CFG_CTRL_NB: out_nb <= cfg_data[15:0].
  - CFG_CTRL_START: start.
- Start latches pass_len, pool_nb and out_nb into working copies. Later config writes do not affect a running job.
- One-hot FSM: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - Start with pass_len==0 or out_nb==0: set err, stay IDLE.
  - Otherwise clear err, clear all counters, go RUN.
- RUN:
  - src_rdy = image_rdy; image_val = src_val.
  - A beat transfers on image_val & image_rdy.
  - beat_cnt counts 0..pass_len-1. image_last = (beat_cnt == pass_len-1). Wrap to 0 on the last transfer.
  - On each last transfer, pass_cnt counts 0..pool_nb. One pooled output needs pool_nb+1 passes. pass_cnt wraps to 0 and win_cnt increments.
  - When the transfer completes window out_nb (win_cnt reaching out_nb), go DRAIN in the same cycle.
- DRAIN: src_rdy=0, image_val=0.
- res_cnt increments on result_val & result_rdy in any non-IDLE state. When res_cnt reaches out_nb, go DONE.
- DONE: lasts one cycle; done=1; next state IDLE.
- busy = RUN | DRAIN | DONE.
- Start while busy is ignored; err is unchanged.
- Counter widths: beat_cnt and res_cnt/win_cnt 16 bits; pass_cnt 8 bits. No overflow is possible within the latched limits.
- Simultaneous events:
  - A result handshake in the same cycle as the final beat is counted.
  - If the final result handshake lands while still in RUN (impossible with a real `layers`, legal on the bench), DRAIN is entered for one cycle and DONE follows.
- Reset (rst=0 at a clock edge): FSM to IDLE, all counters and err cleared, done=0. Any in-flight beat is abandoned.

## Timing
- Reset values: src_rdy 0, image_val 0, image_last 0, busy 0, done 0, err 0.
- image_bus, image_val, src_rdy and image_last are combinational from src_*, image_rdy, state and counters. Zero latency, no buffering.
- IDLE→RUN: the first beat can transfer the cycle after the start write.
- Last beat of the job → DRAIN next cycle. image_val is 0 from then on.
- Final result handshake at cycle N → done=1 at N+1, busy=0 at N+2.
- image_val never depends on image_rdy (AXI-style; no combinational loop from image_rdy).

## Structure
- Append CFG_CTRL_LEN, CFG_CTRL_NB and CFG_CTRL_START to `cfg_parameters.vh`, alongside CFG_LAYERS. All blocks decode the same addresses.
- FSM state indices are localparams in this module.
- No sub-module; a single flat module of about 200 lines.

## Test plan
- pass_len=3, pool_nb=0, out_nb=2, src always valid, image_rdy=1:
  - Exactly 6 beats transfer; image_last on beats 3 and 6.
  - After 2 result handshakes, done pulses once and busy drops.
- pass_len=2, pool_nb=3, out_nb=1:
  - 8 beats transfer with image_last on every 2nd beat.
  - DRAIN holds image_val=0 until 1 result handshake.
- Random src_val and image_rdy gaps with pass_len=5, pool_nb=1, out_nb=3:
  - Beat count is 30 and data order is preserved.
  - image_last aligns to every 5th transfer.
- Start with pass_len=0 → err=1, busy stays 0. Valid start afterwards → err=0, job runs.
- Rewriting CFG_CTRL_LEN and issuing a second start mid-job → ignored; the job completes with the original geometry.
- rst=0 mid-RUN (beat_cnt=2) → next cycle all outputs 0, FSM IDLE. A new start runs a full job with beat_cnt from 0.

Source files
------------

// File: rtl/layers_ctrl_pkg.sv
// Shared constants and types for the layers job sequencer.
// Config addresses decoded by every block on the config bus; FSM state type.
package layers_ctrl_pkg;

  localparam int CFG_LAYERS     = 1;
  localparam int CFG_CTRL_LEN   = 8;
  localparam int CFG_CTRL_NB    = 9;
  localparam int CFG_CTRL_START = 10;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RUN   = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

endpackage

// File: rtl/layers_ctrl_if.sv
// Stream bundle around layers_ctrl: upstream image beats, the metered image
// stream into layers, and the snooped result handshake. master = sequencer.
interface layers_ctrl_if #(
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16
);

  logic [GROUP_NB*IMG_WIDTH-1:0] src_bus;
  logic                          src_val;
  logic                          src_rdy;
  logic [GROUP_NB*IMG_WIDTH-1:0] image_bus;
  logic                          image_last;
  logic                          image_val;
  logic                          image_rdy;
  logic                          result_val;
  logic                          result_rdy;

  modport master (
    input  src_bus, src_val, image_rdy,
    input  result_val, result_rdy,
    output src_rdy, image_bus, image_last, image_val
  );

  modport slave (
    output src_bus, src_val, image_rdy,
    output result_val, result_rdy,
    input  src_rdy, image_bus, image_last, image_val
  );

endinterface

// File: rtl/layers_ctrl.sv
// Job sequencer: snoops config, meters image beats into layers framed by
// image_last, counts result handshakes. Ports: clk, rst (sync, active-low),
// cfg_data/cfg_addr/cfg_valid snoop, io (stream bundle), busy, done, err.
module layers_ctrl
  import layers_ctrl_pkg::*;
#(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cfg_data,
  input  logic [CFG_AWIDTH-1:0] cfg_addr,
  input  logic                  cfg_valid,
  layers_ctrl_if.master         io,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;
  localparam int S_DONE  = 3;

  state_t state;

  logic [15:0] pass_len;
  logic [15:0] out_nb;
  logic [7:0]  pool_nb;
  logic [15:0] len_q;
  logic [15:0] nb_q;
  logic [7:0]  pool_q;
  logic [15:0] beat_cnt;
  logic [7:0]  pass_cnt;
  logic [15:0] win_cnt;
  logic [15:0] res_cnt;
  logic [15:0] res_nxt;

  logic run;
  logic start;
  logic xfer;
  logic last_beat;
  logic pass_end;
  logic job_end;
  logic res_hs;
  logic cfg_unused;

  logic [GROUP_NB*IMG_WIDTH-1:0] beat;

  function automatic logic hit(input int a);
    return cfg_valid && cfg_addr == CFG_AWIDTH'(a);
  endfunction

  assign cfg_unused = ^cfg_data[CFG_DWIDTH-1:16];

  assign start = hit(CFG_CTRL_START);
  assign run   = state[S_RUN];

  // Pure pass-through: no buffering between fetch and layers.
  assign beat          = io.src_bus;
  assign io.image_bus  = beat;
  assign io.image_val  = run & io.src_val;
  assign io.src_rdy    = run & io.image_rdy;
  assign last_beat     = beat_cnt == len_q - 16'd1;
  assign io.image_last = run & last_beat;

  assign xfer     = io.image_val & io.image_rdy;
  assign pass_end = pass_cnt == pool_q;
  assign job_end  = xfer & last_beat & pass_end
                  & (win_cnt + 16'd1 == nb_q);

  assign res_hs  = ~state[S_IDLE] & io.result_val & io.result_rdy;
  assign res_nxt = res_cnt + 16'(res_hs);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pass_len <= '0;
      out_nb   <= '0;
      pool_nb  <= '0;
      len_q    <= '0;
      nb_q     <= '0;
      pool_q   <= '0;
      beat_cnt <= '0;
      pass_cnt <= '0;
      win_cnt  <= '0;
      res_cnt  <= '0;
    end else begin
      done    <= 1'b0;
      res_cnt <= res_nxt;
      if (hit(CFG_LAYERS))   pool_nb  <= cfg_data[15:8];
      if (hit(CFG_CTRL_LEN)) pass_len <= cfg_data[15:0];
      if (hit(CFG_CTRL_NB))  out_nb   <= cfg_data[15:0];
      unique case (1'b1)
        state[S_IDLE]: begin
          if (start) begin
            if (pass_len == '0 || out_nb == '0) begin
              err <= 1'b1;
            end else begin
              err      <= 1'b0;
              len_q    <= pass_len;
              nb_q     <= out_nb;
              pool_q   <= pool_nb;
              beat_cnt <= '0;
              pass_cnt <= '0;
              win_cnt  <= '0;
              res_cnt  <= '0;
              busy     <= 1'b1;
              state    <= RUN;
            end
          end
        end
        state[S_RUN]: begin
          if (xfer) begin
            if (last_beat) begin
              beat_cnt <= '0;
              if (pass_end) begin
                pass_cnt <= '0;
                win_cnt  <= win_cnt + 16'd1;
              end else begin
                pass_cnt <= pass_cnt + 8'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end
          if (job_end) state <= DRAIN;
        end
        state[S_DRAIN]: begin
          // >= so results that all arrived during RUN still finish.
          if (res_nxt >= nb_q) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        state[S_DONE]: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
